// File: rtl/hazard_unit.sv
// Pipeline hazard unit: data-stall detection, bypass select, mult/div busy tracking, stall counter.
// Optional macro HAZARD_FWD_EN enables forwarding; without it every producer match stalls.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  input  logic [2:0]  tuse_rs,
  input  logic [2:0]  tuse_rt,
  input  logic        md_use_D,
  input  logic [4:0]  A3_E,
  input  logic        RegWrite_E,
  input  logic [2:0]  tnew_E,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic [4:0]  A3_M,
  input  logic        RegWrite_M,
  input  logic [2:0]  tnew_M,
  input  logic [4:0]  A3_W,
  input  logic        RegWrite_W,
  output logic        stall,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;
  logic        data_stall, md_stall;

  // Register 0 and operands marked unused (tuse = 7) never produce a match.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst,
                               input logic we, input logic [2:0] tuse);
    return (src != 5'd0) && (src == dst) && we && (tuse != 3'd7);
  endfunction

  assign rs_e = hit(A1_D, A3_E, RegWrite_E, tuse_rs);
  assign rs_m = hit(A1_D, A3_M, RegWrite_M, tuse_rs);
  assign rs_w = hit(A1_D, A3_W, RegWrite_W, tuse_rs);
  assign rt_e = hit(A2_D, A3_E, RegWrite_E, tuse_rt);
  assign rt_m = hit(A2_D, A3_M, RegWrite_M, tuse_rt);
  assign rt_w = hit(A2_D, A3_W, RegWrite_W, tuse_rt);

`ifdef HAZARD_FWD_EN
  // Youngest producer wins; a not-yet-ready youngest producer means no bypass.
  function automatic logic [1:0] fwd_sel(input logic he, input logic hm, input logic hw,
                                         input logic [2:0] te, input logic [2:0] tm);
    if (he)      return (te == 3'd0) ? 2'd1 : 2'd0;
    else if (hm) return (tm == 3'd0) ? 2'd2 : 2'd0;
    else if (hw) return 2'd3;
    else         return 2'd0;
  endfunction

  assign data_stall = (rs_e && (tuse_rs < tnew_E)) || (rs_m && (tuse_rs < tnew_M)) ||
                      (rt_e && (tuse_rt < tnew_E)) || (rt_m && (tuse_rt < tnew_M));
  assign fwd_rs_D   = fwd_sel(rs_e, rs_m, rs_w, tnew_E, tnew_M);
  assign fwd_rt_D   = fwd_sel(rt_e, rt_m, rt_w, tnew_E, tnew_M);
`else
  logic unused_tnew;
  assign unused_tnew = ^{tnew_E, tnew_M};
  assign data_stall  = rs_e || rs_m || rs_w || rt_e || rt_m || rt_w;
  assign fwd_rs_D    = 2'd0;
  assign fwd_rt_D    = 2'd0;
`endif

  // md_start_E is masked during reset so it cannot raise busy or stall.
  assign md_busy  = !reset && (md_start_E || (md_cnt_q != 4'd0));
  assign md_stall = md_use_D && md_busy;
  assign stall    = data_stall || md_stall;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_E)
      md_cnt_d = md_div_E ? DIV_CYC : MULT_CYC;
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
    stall_cnt_d = stall ? (stall_cnt_q + 16'd1) : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus queues expected outputs, a negedge monitor compares.
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1_D, A2_D, A3_E, A3_M, A3_W;
  logic [2:0]  tuse_rs, tuse_rt, tnew_E, tnew_M;
  logic        md_use_D, RegWrite_E, md_start_E, md_div_E, RegWrite_M, RegWrite_W;
  logic        stall, md_busy;
  logic [1:0]  fwd_rs_D, fwd_rt_D;
  logic [15:0] stall_cnt;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .A1_D(A1_D), .A2_D(A2_D), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .md_use_D(md_use_D),
    .A3_E(A3_E), .RegWrite_E(RegWrite_E), .tnew_E(tnew_E), .md_start_E(md_start_E),
    .md_div_E(md_div_E), .A3_M(A3_M), .RegWrite_M(RegWrite_M), .tnew_M(tnew_M),
    .A3_W(A3_W), .RegWrite_W(RegWrite_W),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk({mon_e.name, ".stall"}, {15'd0, stall}, {15'd0, mon_e.stall});
      chk({mon_e.name, ".fwd_rs"}, {14'd0, fwd_rs_D}, {14'd0, mon_e.frs});
      chk({mon_e.name, ".fwd_rt"}, {14'd0, fwd_rt_D}, {14'd0, mon_e.frt});
      chk({mon_e.name, ".md_busy"}, {15'd0, md_busy}, {15'd0, mon_e.busy});
      chk({mon_e.name, ".stall_cnt"}, stall_cnt, mon_e.cnt);
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic push(input string nm, input logic es, input logic [1:0] efr,
                      input logic [1:0] eft, input logic eb);
    exp_t e;
    if (reset) exp_cnt = 16'd0;
    e.name = nm; e.stall = es; e.frs = efr; e.frt = eft; e.busy = eb; e.cnt = exp_cnt;
    q.push_back(e);
    @(posedge clk);
    if (reset) exp_cnt = 16'd0;
    else if (es) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  task automatic clr();
    A1_D = 5'd0; A2_D = 5'd0; A3_E = 5'd0; A3_M = 5'd0; A3_W = 5'd0;
    tuse_rs = 3'd7; tuse_rt = 3'd7; tnew_E = 3'd0; tnew_M = 3'd0;
    md_use_D = 1'b0; RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    md_start_E = 1'b0; md_div_E = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clr();
    @(posedge clk); @(posedge clk); #1;

    // Reset state; md_start_E/md_use_D ignored while in reset.
    md_start_E = 1'b1; md_use_D = 1'b1;
    push("rst_idle", 1'b0, 2'd0, 2'd0, 1'b0);
    clr();
    reset = 1'b0;
    push("rst_release", 1'b0, 2'd0, 2'd0, 1'b0);

    // lw $3 in E, addu needs rs now.
    A3_E = 5'd3; RegWrite_E = 1'b1; tnew_E = 3'd1; A1_D = 5'd3; tuse_rs = 3'd0;
    push("lw_use", 1'b1, 2'd0, 2'd0, 1'b0);
    tuse_rs = 3'd7;
    push("tuse7", 1'b0, 2'd0, 2'd0, 1'b0);
    tuse_rs = 3'd1;
    push("tuse_eq_tnew", FWD ? 1'b0 : 1'b1, 2'd0, 2'd0, 1'b0);
    clr();
    push("cnt_after", 1'b0, 2'd0, 2'd0, 1'b0);

    // rt match in M, not ready.
    A3_M = 5'd6; RegWrite_M = 1'b1; tnew_M = 3'd2; A2_D = 5'd6; tuse_rt = 3'd1;
    push("m_rt_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    clr();

    // E and M both write $5, both ready: E has priority.
    A3_E = 5'd5; RegWrite_E = 1'b1; A3_M = 5'd5; RegWrite_M = 1'b1;
    A1_D = 5'd5; tuse_rs = 3'd0;
    push("e_prio", FWD ? 1'b0 : 1'b1, FWD ? 2'd1 : 2'd0, 2'd0, 1'b0);
    clr();

    // Bypass from M on rt while E writes an unrelated register.
    A3_E = 5'd8; RegWrite_E = 1'b1; tnew_E = 3'd2;
    A3_M = 5'd9; RegWrite_M = 1'b1; A2_D = 5'd9; tuse_rt = 3'd0;
    push("m_fwd_rt", FWD ? 1'b0 : 1'b1, 2'd0, FWD ? 2'd2 : 2'd0, 1'b0);
    clr();

    // W-only match on $7.
    A3_W = 5'd7; RegWrite_W = 1'b1; A2_D = 5'd7; tuse_rt = 3'd1;
    push("w_fwd_rt", FWD ? 1'b0 : 1'b1, 2'd0, FWD ? 2'd3 : 2'd0, 1'b0);
    clr();

    // Register 0 never matches.
    A3_W = 5'd0; RegWrite_W = 1'b1; A3_E = 5'd0; RegWrite_E = 1'b1; tnew_E = 3'd3;
    A2_D = 5'd0; tuse_rt = 3'd1; A1_D = 5'd0; tuse_rs = 3'd0;
    push("reg0", 1'b0, 2'd0, 2'd0, 1'b0);
    clr();

    // Destination with RegWrite = 0 does not match.
    A3_E = 5'd4; tnew_E = 3'd2; A1_D = 5'd4; tuse_rs = 3'd0;
    push("no_we", 1'b0, 2'd0, 2'd0, 1'b0);
    clr();

    // E writes $4 ready, consumer needs it in 2 cycles.
    A3_E = 5'd4; RegWrite_E = 1'b1; A1_D = 5'd4; tuse_rs = 3'd2;
    push("e_ready", FWD ? 1'b0 : 1'b1, FWD ? 2'd1 : 2'd0, 2'd0, 1'b0);
    clr();

    // div with md_use_D held: 11 stall cycles.
    md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b1;
    push("div_start", 1'b1, 2'd0, 2'd0, 1'b1);
    md_start_E = 1'b0;
    for (int i = 1; i <= 10; i++) push($sformatf("div_busy%0d", i), 1'b1, 2'd0, 2'd0, 1'b1);
    push("div_done", 1'b0, 2'd0, 2'd0, 1'b0);
    clr();

    // mult: start + 5 busy cycles.
    md_start_E = 1'b1;
    push("mul_start", 1'b0, 2'd0, 2'd0, 1'b1);
    md_start_E = 1'b0;
    for (int i = 1; i <= 5; i++) push($sformatf("mul_busy%0d", i), 1'b0, 2'd0, 2'd0, 1'b1);
    push("mul_done", 1'b0, 2'd0, 2'd0, 1'b0);

    // Restart while busy reloads the counter.
    md_start_E = 1'b1;
    push("rs_mul", 1'b0, 2'd0, 2'd0, 1'b1);
    md_start_E = 1'b0;
    push("rs_b1", 1'b0, 2'd0, 2'd0, 1'b1);
    push("rs_b2", 1'b0, 2'd0, 2'd0, 1'b1);
    md_start_E = 1'b1; md_div_E = 1'b1;
    push("rs_div", 1'b0, 2'd0, 2'd0, 1'b1);
    md_start_E = 1'b0;
    for (int i = 1; i <= 10; i++) push($sformatf("rs_busy%0d", i), 1'b0, 2'd0, 2'd0, 1'b1);
    push("rs_done", 1'b0, 2'd0, 2'd0, 1'b0);
    clr();

    // mult start, reset two cycles later abandons it.
    md_start_E = 1'b1;
    push("ab_mul", 1'b0, 2'd0, 2'd0, 1'b1);
    md_start_E = 1'b0;
    push("ab_b1", 1'b0, 2'd0, 2'd0, 1'b1);
    reset = 1'b1;
    push("ab_rst", 1'b0, 2'd0, 2'd0, 1'b0);
    md_start_E = 1'b1; md_use_D = 1'b1;
    A3_E = 5'd3; RegWrite_E = 1'b1; tnew_E = 3'd1; A1_D = 5'd3; tuse_rs = 3'd0;
    push("ab_rst_data", 1'b1, 2'd0, 2'd0, 1'b0);
    clr();
    reset = 1'b0; md_use_D = 1'b1;
    push("ab_release", 1'b0, 2'd0, 2'd0, 1'b0);
    push("ab_idle", 1'b0, 2'd0, 2'd0, 1'b0);
    clr();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
